// File: rtl/fir_channel_feeder.sv
// Snapshots a frame of NUM_CH parallel ADC samples and streams them one channel
// at a time to the FIR core, inserting GAP idle cycles between channels.
module fir_channel_feeder #(
   parameter int NUM_CH = 4,
   parameter int DW     = 16,
   parameter int CW     = 2,
   parameter int GAP    = 19
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 data_ready,
   input  logic [NUM_CH*DW-1:0] in_data,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic [DW-1:0]        m_tdata,
   output logic [CW-1:0]        m_tuser,
   output logic                 busy,
   output logic                 frame_done,
   output logic [7:0]           overrun_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      GAP_WAIT = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
   localparam logic [5:0]    GAP_LOAD = 6'(GAP);

   state_t        state_reg;
   logic [CW-1:0] ch_reg;
   logic [5:0]    gap_cnt_reg;
   logic [DW-1:0] in_word  [NUM_CH];
   logic [DW-1:0] snap_reg [NUM_CH];

   logic          handshake;
   logic          last_hs;
   logic          accept;
   logic [CW-1:0] ch_next;

   assign handshake = m_tvalid & m_tready;
   assign last_hs   = (state_reg == SEND) && handshake && (ch_reg == LAST_CH);
   // A strobe coinciding with the final handshake starts the next frame
   // immediately instead of being counted as an overrun.
   assign accept    = data_ready && ((state_reg == IDLE) || last_hs);
   assign ch_next   = ch_reg + CW'(1);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_snap
         assign in_word[gi] = in_data[gi*DW +: DW];

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               snap_reg[gi] <= '0;
            end else if (accept) begin
               snap_reg[gi] <= in_word[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         ch_reg      <= '0;
         gap_cnt_reg <= '0;
         m_tvalid    <= 1'b0;
         m_tdata     <= '0;
         m_tuser     <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         frame_done <= 1'b0;

         if (data_ready && !accept && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_reg <= SEND;
                  ch_reg    <= '0;
                  m_tvalid  <= 1'b1;
                  m_tdata   <= in_word[0];
                  m_tuser   <= '0;
                  busy      <= 1'b1;
               end
            end

            SEND: begin
               if (handshake) begin
                  if (ch_reg == LAST_CH) begin
                     frame_done <= 1'b1;
                     if (data_ready) begin
                        state_reg <= SEND;
                        ch_reg    <= '0;
                        m_tvalid  <= 1'b1;
                        m_tdata   <= in_word[0];
                        m_tuser   <= '0;
                        busy      <= 1'b1;
                     end else begin
                        state_reg <= IDLE;
                        m_tvalid  <= 1'b0;
                        busy      <= 1'b0;
                     end
                  end else if (GAP == 0) begin
                     ch_reg  <= ch_next;
                     m_tdata <= snap_reg[ch_next];
                     m_tuser <= ch_next;
                  end else begin
                     state_reg   <= GAP_WAIT;
                     m_tvalid    <= 1'b0;
                     gap_cnt_reg <= GAP_LOAD;
                  end
               end
            end

            GAP_WAIT: begin
               // Counter holds the remaining low cycles; present on the last one.
               if (gap_cnt_reg <= 6'd1) begin
                  state_reg   <= SEND;
                  gap_cnt_reg <= '0;
                  ch_reg      <= ch_next;
                  m_tvalid    <= 1'b1;
                  m_tdata     <= snap_reg[ch_next];
                  m_tuser     <= ch_next;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 6'd1;
               end
            end

            default: begin
               state_reg <= IDLE;
               m_tvalid  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_channel_feeder.sv
// Bench for fir_channel_feeder: a GAP=0 instance driven from a vector table, and
// a GAP=19 instance exercised by directed sequences and a random timeline model.
module tb_fir_channel_feeder;

   localparam int NUM_CH = 4;
   localparam int DW     = 16;
   localparam int CW     = 2;
   localparam int GAP    = 19;

   logic        clk = 1'b0;
   logic        reset;

   logic        data_ready;
   logic [63:0] in_data;
   logic        m_tvalid;
   logic        m_tready;
   logic [15:0] m_tdata;
   logic [1:0]  m_tuser;
   logic        busy;
   logic        frame_done;
   logic [7:0]  overrun_cnt;

   logic        dr0;
   logic [63:0] din0;
   logic        tv0;
   logic        tr0;
   logic [15:0] td0;
   logic [1:0]  tu0;
   logic        busy0;
   logic        done0;
   logic [7:0]  ovr0;

   int errors = 0;
   int checks = 0;
   int lows;

   always #5 clk = ~clk;

   fir_channel_feeder #(.NUM_CH(NUM_CH), .DW(DW), .CW(CW), .GAP(GAP)) dut (
      .clk(clk), .reset(reset), .data_ready(data_ready), .in_data(in_data),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tuser(m_tuser),
      .busy(busy), .frame_done(frame_done), .overrun_cnt(overrun_cnt)
   );

   fir_channel_feeder #(.NUM_CH(NUM_CH), .DW(DW), .CW(CW), .GAP(0)) dut0 (
      .clk(clk), .reset(reset), .data_ready(dr0), .in_data(din0),
      .m_tvalid(tv0), .m_tready(tr0), .m_tdata(td0), .m_tuser(tu0),
      .busy(busy0), .frame_done(done0), .overrun_cnt(ovr0)
   );

   typedef struct {
      logic        dr;
      logic [63:0] din;
      logic        rdy;
      logic        v;
      logic [1:0]  u;
      logic [15:0] d;
      logic        b;
      logic        done;
      logic [7:0]  ovr;
   } vec_t;

   vec_t tbl [18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!m_tvalid && n < budget) begin
         tick();
         n++;
      end
      check("tvalid_reached", m_tvalid, 1);
   endtask

   // Expects m_tready=1; walks channels from_ch..NUM_CH-1 and checks frame_done.
   task automatic run_channels(input string tag, input logic [63:0] frame, input int from_ch);
      int n;
      for (int k = from_ch; k < NUM_CH; k++) begin
         wait_valid(40, n);
         check({tag, "_tuser"}, m_tuser, k);
         check({tag, "_tdata"}, m_tdata, frame[k*16 +: 16]);
         $display("xfer %s ch=%0d data=%h", tag, m_tuser, m_tdata);
         tick();
      end
      check({tag, "_done"}, frame_done, 1);
      check({tag, "_busy_end"}, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // GAP=0 vector table: {dr, din, tready, valid, tuser, tdata, busy, done, ovr}
      tbl[0]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 2'd0, 16'h0,    1'b0, 1'b0, 8'd0};
      tbl[1]  = '{1'b1, 64'h0D0D_0C0C_0B0B_0A0A, 1'b1, 1'b1, 2'd0, 16'h0A0A, 1'b1, 1'b0, 8'd0};
      tbl[2]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 2'd1, 16'h0B0B, 1'b1, 1'b0, 8'd0};
      tbl[3]  = '{1'b0, 64'h0,                   1'b0, 1'b1, 2'd1, 16'h0B0B, 1'b1, 1'b0, 8'd0};
      tbl[4]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 2'd2, 16'h0C0C, 1'b1, 1'b0, 8'd1};
      tbl[5]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 2'd3, 16'h0D0D, 1'b1, 1'b0, 8'd1};
      tbl[6]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 2'd0, 16'h0,    1'b0, 1'b1, 8'd1};
      tbl[7]  = '{1'b1, 64'h2444_2333_2222_2111, 1'b1, 1'b1, 2'd0, 16'h2111, 1'b1, 1'b0, 8'd1};
      tbl[8]  = '{1'b0, 64'h0,                   1'b0, 1'b1, 2'd0, 16'h2111, 1'b1, 1'b0, 8'd1};
      tbl[9]  = '{1'b0, 64'h0,                   1'b1, 1'b1, 2'd1, 16'h2222, 1'b1, 1'b0, 8'd1};
      tbl[10] = '{1'b0, 64'h0,                   1'b1, 1'b1, 2'd2, 16'h2333, 1'b1, 1'b0, 8'd1};
      tbl[11] = '{1'b0, 64'h0,                   1'b1, 1'b1, 2'd3, 16'h2444, 1'b1, 1'b0, 8'd1};
      tbl[12] = '{1'b1, 64'h3444_3333_3222_3111, 1'b1, 1'b1, 2'd0, 16'h3111, 1'b1, 1'b1, 8'd1};
      tbl[13] = '{1'b0, 64'h0,                   1'b1, 1'b1, 2'd1, 16'h3222, 1'b1, 1'b0, 8'd1};
      tbl[14] = '{1'b0, 64'h0,                   1'b1, 1'b1, 2'd2, 16'h3333, 1'b1, 1'b0, 8'd1};
      tbl[15] = '{1'b0, 64'h0,                   1'b1, 1'b1, 2'd3, 16'h3444, 1'b1, 1'b0, 8'd1};
      tbl[16] = '{1'b0, 64'h0,                   1'b1, 1'b0, 2'd0, 16'h0,    1'b0, 1'b1, 8'd1};
      tbl[17] = '{1'b0, 64'h0,                   1'b1, 1'b0, 2'd0, 16'h0,    1'b0, 1'b0, 8'd1};

      reset = 1'b0;
      data_ready = 1'b0; in_data = '0; m_tready = 1'b1;
      dr0 = 1'b0; din0 = '0; tr0 = 1'b1;
      repeat (3) tick();
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_tuser", m_tuser, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      check("rst_ovr", overrun_cnt, 0);
      check("rst0_all", {tv0, td0, tu0, busy0, done0, ovr0}, 0);
      reset = 1'b1;
      tick();

      // GAP=0 table: back-to-back channels, stalls, overrun, coincident restart
      for (int i = 0; i < 18; i++) begin
         dr0 = tbl[i].dr; din0 = tbl[i].din; tr0 = tbl[i].rdy;
         tick();
         check($sformatf("tbl%0d_tvalid", i), tv0, tbl[i].v);
         if (tbl[i].v) begin
            check($sformatf("tbl%0d_tuser", i), tu0, tbl[i].u);
            check($sformatf("tbl%0d_tdata", i), td0, tbl[i].d);
         end
         check($sformatf("tbl%0d_busy", i), busy0, tbl[i].b);
         check($sformatf("tbl%0d_done", i), done0, tbl[i].done);
         check($sformatf("tbl%0d_ovr", i), ovr0, tbl[i].ovr);
         $display("vec %0d dr=%0b rdy=%0b -> tvalid=%0b tuser=%0d tdata=%h done=%0b",
                  i, tbl[i].dr, tbl[i].rdy, tv0, tu0, td0, done0);
      end
      dr0 = 1'b0;

      // Basic frame, tready tied high
      in_data = 64'h4444_3333_2222_1111; data_ready = 1'b1; m_tready = 1'b1;
      tick();
      data_ready = 1'b0; in_data = {$urandom, $urandom};
      for (int c = 0; c <= 81; c++) begin
         logic ev;
         ev = (c % 20 == 0) && (c < 80);
         check($sformatf("basic_c%0d_tvalid", c), m_tvalid, ev);
         if (ev) begin
            check("basic_tuser", m_tuser, c / 20);
            check("basic_tdata", m_tdata, 16'h1111 * (c / 20 + 1));
            $display("xfer basic ch=%0d data=%h", m_tuser, m_tdata);
         end
         check($sformatf("basic_c%0d_done", c), frame_done, c == 61);
         check($sformatf("basic_c%0d_busy", c), busy, c <= 60);
         if (c < 81) tick();
      end
      check("basic_ovr", overrun_cnt, 0);

      // Backpressure on channel 1
      in_data = 64'h4444_3333_2222_1111; data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check("bp_ch0", {m_tvalid, m_tuser, m_tdata}, {1'b1, 2'd0, 16'h1111});
      tick();
      wait_valid(40, lows);
      check("bp_gap_ch1", lows, 19);
      m_tready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check($sformatf("bp_hold%0d", i), {m_tvalid, m_tuser, m_tdata}, {1'b1, 2'd1, 16'h2222});
         tick();
      end
      check("bp_hold_8th", {m_tvalid, m_tuser, m_tdata}, {1'b1, 2'd1, 16'h2222});
      m_tready = 1'b1;
      $display("xfer bp ch=1 data=%h after stall", m_tdata);
      tick();
      wait_valid(40, lows);
      check("bp_gap_ch2", lows, 19);
      run_channels("bp", 64'h4444_3333_2222_1111, 2);
      tick();

      // Three overruns during the gap leave the frame untouched
      in_data = 64'h8888_7777_6666_5555; data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check("ovr_ch0", m_tdata, 16'h5555);
      tick();
      for (int i = 0; i < 3; i++) begin
         in_data = {$urandom, $urandom}; data_ready = 1'b1;
         tick();
         data_ready = 1'b0;
         tick();
      end
      check("ovr_cnt3", overrun_cnt, 3);
      run_channels("ovr", 64'h8888_7777_6666_5555, 1);
      tick();

      // Back-to-back: strobe coincident with the channel-3 handshake
      in_data = 64'h4444_3333_2222_1111; data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_valid(40, lows);
         tick();
      end
      wait_valid(40, lows);
      check("b2b_ch3", m_tuser, 3);
      in_data = 64'hDDDD_CCCC_BBBB_AAAA; data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check("b2b_tvalid", m_tvalid, 1);
      check("b2b_tuser", m_tuser, 0);
      check("b2b_tdata", m_tdata, 16'hAAAA);
      check("b2b_done", frame_done, 1);
      check("b2b_busy", busy, 1);
      check("b2b_ovr", overrun_cnt, 3);
      tick();
      check("b2b_done_once", frame_done, 0);
      run_channels("b2b", 64'hDDDD_CCCC_BBBB_AAAA, 1);
      tick();

      // Random traffic against a timeline model
      reset = 1'b0;
      tick();
      reset = 1'b1;
      begin
         logic [15:0] mw [NUM_CH];
         bit mact;
         int mch, mnext, movr, t;
         mact = 0; mch = 0; mnext = 0; movr = 0; t = 0;
         for (int k = 0; k < NUM_CH; k++) mw[k] = '0;
         for (int n = 0; n < 4000; n++) begin
            logic [63:0] r_din;
            bit r_dr, r_rdy, ev, hs, last;
            r_dr  = ($urandom_range(0, 39) == 0);
            r_din = {$urandom, $urandom};
            r_rdy = ($urandom_range(0, 9) < 7);
            ev = mact && (t >= mnext);
            check("rnd_tvalid", m_tvalid, ev);
            if (ev) begin
               check("rnd_tuser", m_tuser, mch);
               check("rnd_tdata", m_tdata, mw[mch]);
            end
            hs   = ev && r_rdy;
            last = hs && (mch == NUM_CH - 1);
            if (hs) begin
               $display("xfer rnd t=%0d ch=%0d data=%h", t, mch, mw[mch]);
               if (last) mact = 0;
               else begin
                  mch++;
                  mnext = t + 1 + GAP;
               end
            end
            if (r_dr) begin
               if (!mact) begin
                  for (int k = 0; k < NUM_CH; k++) mw[k] = r_din[k*16 +: 16];
                  mact = 1; mch = 0; mnext = t + 1;
               end else if (movr < 255) begin
                  movr++;
               end
            end
            data_ready = r_dr; in_data = r_din; m_tready = r_rdy;
            tick();
            t++;
            check("rnd_done", frame_done, last);
            check("rnd_busy", busy, mact);
            check("rnd_ovr", overrun_cnt, movr);
         end
      end
      data_ready = 1'b0; m_tready = 1'b1;
      repeat (100) tick();

      // Saturation: strobe every cycle while frames run
      data_ready = 1'b1;
      repeat (300) tick();
      data_ready = 1'b0;
      check("ovr_saturate", overrun_cnt, 255);
      repeat (100) tick();
      check("sat_idle", {m_tvalid, busy}, 0);

      // Asynchronous reset during the gap after channel 1
      in_data = 64'h4444_3333_2222_1111; data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      tick();
      wait_valid(40, lows);
      tick();
      repeat (3) tick();
      #2 reset = 1'b0;
      #1;
      check("arst_tvalid", m_tvalid, 0);
      check("arst_tdata", m_tdata, 0);
      check("arst_tuser", m_tuser, 0);
      check("arst_busy", busy, 0);
      check("arst_done", frame_done, 0);
      check("arst_ovr", overrun_cnt, 0);
      #3 reset = 1'b1;
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 200; i++) begin
            tick();
            if (m_tvalid || frame_done || busy) bad++;
         end
         check("arst_quiet", bad, 0);
      end
      in_data = 64'h0004_0003_0002_0001; data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check("arst_restart", {m_tvalid, m_tuser, m_tdata}, {1'b1, 2'd0, 16'h0001});
      run_channels("arst", 64'h0004_0003_0002_0001, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fir_channel_feeder.md
Name: fir_channel_feeder

Overview:
- Upstream sequencer for the multi-channel pot-feedback FIR filter.
- On each data_ready strobe, snapshots NUM_CH parallel ADC samples.
- Presents the samples one channel at a time on an AXI4-Stream-style master port: tdata carries the sample, tuser carries the channel id.
- Enforces a programmable idle gap between channels so the filter core has its per-sample processing cycles.
- Replaces ad-hoc edge-triggered feeding with a single-clock registered handshake.

Parameters:
- NUM_CH, 4, number of channels; 2..8.
- DW, 16, sample width in bits.
- CW, 2, channel-id width; must satisfy 2^CW >= NUM_CH.
- GAP, 19, idle cycles (tvalid low) between a channel's handshake and presentation of the next channel; 0..63.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- data_ready  in  1  one-cycle strobe: in_data holds a new frame.
- in_data  in  NUM_CH*DW  packed samples; channel k at bits [k*DW+DW-1 : k*DW].
- m_tvalid  out  1  sample valid to filter.
- m_tready  in  1  filter accepts sample.
- m_tdata  out  DW  sample for channel m_tuser.
- m_tuser  out  CW  channel id, 0..NUM_CH-1.
- busy  out  1  frame in progress; high from first presentation until the last handshake.
- frame_done  out  1  one-cycle pulse when the last channel's handshake completes.
- overrun_cnt  out  8  count of dropped data_ready strobes; saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous), all outputs 0:
  - m_tvalid=0, m_tdata=0, m_tuser=0, busy=0, frame_done=0, overrun_cnt=0.
  - Snapshot register cleared; state=IDLE; channel index=0; gap counter=0.
  - Reset mid-frame aborts the frame; no frame_done is issued.
- States: IDLE, SEND, GAP.
- IDLE:
  - data_ready=1 at edge E0: latch all of in_data into the snapshot; channel index=0; go to SEND.
  - From E0, m_tvalid=1, m_tdata=snapshot[0], m_tuser=0, busy=1.
  - Latency from data_ready to first m_tvalid is one clock.
- SEND:
  - m_tvalid held high.
  - m_tdata and m_tuser held stable until m_tvalid & m_tready is sampled (AXI rule; no retraction, no data change while stalled).
  - On handshake with index < NUM_CH-1:
    - GAP>0: m_tvalid=0, load gap counter=GAP, go to GAP.
    - GAP=0: index+1, stay in SEND with the next channel's data on the next cycle (back-to-back).
  - On handshake with index = NUM_CH-1: m_tvalid=0, busy=0, frame_done=1 for exactly one cycle, go to IDLE.
- GAP:
  - m_tvalid=0; decrement counter each cycle.
  - When it expires after exactly GAP low cycles: index+1, present the next channel in SEND.
  - m_tready is ignored in GAP.
- Timing with m_tready tied high:
  - Channel k asserts tvalid for one cycle starting E0+k*(GAP+1).
  - Frame length is NUM_CH*(GAP+1) cycles; 80 for the defaults.
- Overrun:
  - data_ready while in SEND or GAP is dropped.
  - The snapshot is unchanged and the frame continues.
  - overrun_cnt increments by 1, saturating at 255; it is cleared only by reset.
- Simultaneous data_ready with the final handshake:
  - Counted as accepted, not an overrun.
  - Snapshot reloads; the next cycle presents the new channel 0 (tvalid stays high).
  - busy stays 1; frame_done still pulses for the completed frame.
- data_ready in IDLE with frame_done high: accepted normally.
- in_data changes after the snapshot have no effect on the frame in progress.
- m_tuser is zero-extended channel index; indices never exceed NUM_CH-1.

Test Plan:
- Basic frame: GAP=19, tready=1; in_data = {0x4444,0x3333,0x2222,0x1111}, data_ready at E0 -> tvalid pulses at E0, E20, E40, E60 with (tuser,tdata) = (0,0x1111), (1,0x2222), (2,0x3333), (3,0x4444). frame_done high one cycle after E60; busy low then.
- Backpressure: tready=0 for 7 cycles on channel 1 -> tvalid, tdata=0x2222, tuser=1 held for 7 cycles. Handshake on 8th cycle; channel 2 appears exactly 20 cycles later.
- Overrun: three data_ready strobes during GAP of a frame -> frame data unchanged, overrun_cnt=3. 300 strobes during busy frames -> overrun_cnt=255.
- Back-to-back: data_ready coincident with the channel-3 handshake, new in_data 0xAAAA.. -> next cycle tvalid=1, tuser=0, tdata=new ch0 value. frame_done pulses once; overrun_cnt unchanged.
- GAP=0, tready=1: four consecutive cycles of tvalid=1 with tuser 0,1,2,3 -> frame_done on the fifth cycle.
- Async reset: assert reset during GAP after channel 1 -> outputs 0 immediately, without a clock. After release, no tvalid until the next data_ready; no frame_done is ever issued for the aborted frame.
